five_slot_tdm_demux: RTL

//   Receive end of the five-channel select/mux path: takes one shared, time-division-multiplexed

---
 rtl/five_slot_tdm_demux_pkg.sv | 26 ++
 rtl/five_slot_tdm_demux_mod5_slot_counter.sv | 31 +++
 rtl/five_slot_tdm_demux.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/five_slot_tdm_demux_pkg.sv
// Shared slot numbering, FSM states and helpers for the
// five-channel TDM receive path.
package five_slot_tdm_demux_pkg;

  localparam int NUM_CH = 5;
  localparam int SLOT_W = 3;

  localparam logic [SLOT_W-1:0] SLOT_A = 3'd0;
  localparam logic [SLOT_W-1:0] SLOT_B = 3'd1;
  localparam logic [SLOT_W-1:0] SLOT_C = 3'd2;
  localparam logic [SLOT_W-1:0] SLOT_D = 3'd3;
  localparam logic [SLOT_W-1:0] SLOT_E = 3'd4;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Slot codes 5..7 cannot be reached; fold them onto slot 0.
  function automatic logic [SLOT_W-1:0] slot_norm(
    input logic [SLOT_W-1:0] s
  );
    return (s > SLOT_E) ? SLOT_A : s;
  endfunction

endpackage

// File: rtl/five_slot_tdm_demux_mod5_slot_counter.sv
// Mod-5 slot position counter. Ports: clk, rst (sync, high),
// adv (step), load1 (jump to slot 1), clr (to slot 0) -> slot.
module five_slot_tdm_demux_mod5_slot_counter
  import five_slot_tdm_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0] cur;

  assign cur = slot_norm(slot);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= SLOT_A;
    end else if (clr) begin
      slot <= SLOT_A;
    end else if (load1) begin
      slot <= SLOT_B;
    end else if (adv) begin
      slot <= (cur == SLOT_E) ? SLOT_A
                              : cur + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/five_slot_tdm_demux.sv
// TDM receive demux: splits a 5-slot stream into registered a..e.
// Ports: din/din_valid/frame_sync in; a..e, frame_valid, slot,
// locked, sync_err, frame_cnt, err_cnt out.
module five_slot_tdm_demux
  import five_slot_tdm_demux_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] e,
  output logic              frame_valid,
  output logic [2:0]        slot,
  output logic              locked,
  output logic              sync_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  state_t state, state_nx;

  logic [SLOT_W-1:0] cur;
  logic              adv, load1, clr;
  logic              done, err;
  logic [NUM_CH-2:0] stg_we;
  logic [DATA_W-1:0] stage [NUM_CH-1];

  five_slot_tdm_demux_mod5_slot_counter u_cnt (
    .clk   (clk),
    .rst   (rst),
    .adv   (adv),
    .load1 (load1),
    .clr   (clr),
    .slot  (slot)
  );

  assign cur    = slot_norm(slot);
  assign locked = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_HUNT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (din_valid) begin
      if (state == ST_HUNT) begin
        if (frame_sync) state_nx = ST_RUN;
      end else if (!frame_sync && cur == SLOT_A) begin
        state_nx = ST_HUNT;
      end
    end
  end

  always_comb begin
    adv    = 1'b0;
    load1  = 1'b0;
    clr    = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    stg_we = '0;
    if (din_valid) begin
      if (state == ST_HUNT) begin
        // Unsynced samples are dropped without an error.
        if (frame_sync) begin
          load1     = 1'b1;
          stg_we[0] = 1'b1;
        end
      end else begin
        unique case (1'b1)
          frame_sync: begin
            // Sync mid-frame: drop partial frame, restart here.
            err       = (cur != SLOT_A);
            load1     = 1'b1;
            stg_we[0] = 1'b1;
          end
          (!frame_sync && cur == SLOT_A): begin
            err = 1'b1;
            clr = 1'b1;
          end
          (!frame_sync && cur == SLOT_E): begin
            done = 1'b1;
            clr  = 1'b1;
          end
          default: begin
            adv = 1'b1;
            for (int i = 1; i < NUM_CH - 1; i++)
              stg_we[i] = (cur == SLOT_W'(i));
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH - 1; i++)
        stage[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH - 1; i++)
        if (stg_we[i]) stage[i] <= din;
    end
  end

  // Slot-4 sample bypasses staging so all five outputs
  // switch together on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      e           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= done;
      sync_err    <= err;
      if (done) begin
        a         <= stage[0];
        b         <= stage[1];
        c         <= stage[2];
        d         <= stage[3];
        e         <= din;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (err && err_cnt != '1)
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
